spi_cmd_decoder: RTL and testbench

Sits directly downstream of spislave and consumes its received-byte stream (mdata, data_valid_read, data_firstbyte). It drives the byte spislave shifts out next (sdata). It decodes a command/address/data protocol into single-cycle reads and writes on a simple synchronous 16-bit-address, 8-bit-data bus towards registers or memory, with optional address auto-increment. This is the SPI-to-bus bridge of the design.

---
 rtl/spi_cmd_decoder_if.sv | 24 ++
 rtl/spi_cmd_decoder.sv | 122 ++++++++++++
 tb/tb_spi_cmd_decoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-bus signals of the SPI command decoder.
// slave: the decoder. master: the spislave/bus side that feeds it.
interface spi_cmd_decoder_if;
    logic [7:0]  mdata;
    logic        data_valid_read;
    logic        data_firstbyte;
    logic [7:0]  sdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic        busy;

    modport slave (
        input  mdata, data_valid_read, data_firstbyte, bus_rdata,
        output sdata, bus_addr, bus_wdata, bus_we, bus_re, busy
    );

    modport master (
        output mdata, data_valid_read, data_firstbyte, bus_rdata,
        input  sdata, bus_addr, bus_wdata, bus_we, bus_re, busy
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI-to-bus bridge: decodes cmd / addr_hi / addr_lo / data bytes from
// spislave into single-cycle bus reads and writes, with optional address
// auto-increment. Read data is staged into sdata for the next byte slot.
module spi_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_cmd_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_CMD, S_ADDRH, S_ADDRL, S_DATA} state_t;

    // The read-return staging below assumes bus_rdata one cycle after bus_re.
    generate
        if (RD_LATENCY != 1) begin : g_bad_latency
            $error("spi_cmd_decoder: only RD_LATENCY = 1 is supported");
        end
    endgenerate

    state_t      r_state, w_next;
    logic        r_rw, r_ainc;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata, r_sdata;
    logic        r_we, r_re, r_busy;
    logic        r_inc_pend;   // read+ainc: bump address, then issue bus_re
    logic        r_rd_pend;    // bus_rdata is valid this cycle
    logic        w_cmd, w_addrh, w_addrl, w_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_CMD;
        else     r_state <= w_next;
    end

    // Next state and per-strobe decode; a first byte restarts from any state
    always_comb begin
        w_next  = r_state;
        w_cmd   = 1'b0;
        w_addrh = 1'b0;
        w_addrl = 1'b0;
        w_data  = 1'b0;
        if (bus.data_valid_read) begin
            if (bus.data_firstbyte) begin
                w_cmd  = 1'b1;
                w_next = S_ADDRH;
            end else begin
                case (r_state)
                    S_CMD:   w_next = S_CMD;
                    S_ADDRH: begin w_addrh = 1'b1; w_next = S_ADDRL; end
                    S_ADDRL: begin w_addrl = 1'b1; w_next = S_DATA;  end
                    S_DATA:  w_data = 1'b1;
                    default: w_next = S_CMD;
                endcase
            end
        end
    end

    // Datapath: address, bus strobes, write data, sdata staging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw       <= 1'b0;
            r_ainc     <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_sdata    <= 8'h00;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_busy     <= 1'b0;
            r_inc_pend <= 1'b0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_inc_pend <= 1'b0;
            r_rd_pend  <= r_re;
            if (r_rd_pend)
                r_sdata <= bus.bus_rdata;
            // post-increment after a write, 16-bit wrap
            if (r_we && r_ainc)
                r_addr <= r_addr + 16'd1;
            // pre-increment before an auto-increment read
            if (r_inc_pend) begin
                r_addr <= r_addr + 16'd1;
                r_re   <= 1'b1;
            end
            if (w_addrh)
                r_addr[15:8] <= bus.mdata;
            if (w_addrl) begin
                r_addr[7:0] <= bus.mdata;
                r_re        <= r_rw;          // read prefetch
            end
            if (w_data) begin
                if (!r_rw) begin
                    r_we    <= 1'b1;
                    r_wdata <= bus.mdata;
                end else if (r_ainc) begin
                    r_inc_pend <= 1'b1;        // dummy byte discarded
                end else begin
                    r_re <= 1'b1;
                end
            end
            // a command byte aborts anything in flight
            if (w_cmd) begin
                r_rw       <= bus.mdata[7];
                r_ainc     <= bus.mdata[6];
                r_sdata    <= SYNC_BYTE;
                r_busy     <= 1'b1;
                r_re       <= 1'b0;
                r_inc_pend <= 1'b0;
                r_rd_pend  <= 1'b0;
            end
        end
    end

    assign bus.sdata     = r_sdata;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_we    = r_we;
    assign bus.bus_re    = r_re;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed protocol scenarios plus randomized
// transactions checked against a byte-level protocol model.
module tb_spi_cmd_decoder;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cmd_decoder_if bus();
    spi_cmd_decoder #(.SYNC_BYTE(SYNC), .RD_LATENCY(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  mem       [0:65535];   // device memory, written by the DUT
    logic [7:0]  model_mem [0:65535];   // what memory should hold
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [24:0] act_ev[$], exp_ev[$];  // {is_write, addr, wdata}
    logic [7:0]  act_sd[$], exp_sd[$];  // sdata settled after each strobe

    // Memory device: one-cycle read latency
    always @(posedge clk) begin
        if (bus.bus_re) bus.bus_rdata <= mem[bus.bus_addr];
        if (bus.bus_we) mem[bus.bus_addr] <= bus.bus_wdata;
    end

    // Record every bus cycle once per clock; strobes must be exclusive
    always @(negedge clk) begin
        if (bus.bus_we) act_ev.push_back({1'b1, bus.bus_addr, bus.bus_wdata});
        if (bus.bus_re) act_ev.push_back({1'b0, bus.bus_addr, 8'h00});
        if (bus.bus_we || bus.bus_re) begin
            n_checks++;
            if (bus.bus_we && bus.bus_re) begin
                n_fail++;
                $display("FAIL we_re_exclusive: both strobes high at addr %h, required one", bus.bus_addr);
            end
        end
    end

    task automatic clr();
        act_ev.delete(); exp_ev.delete(); act_sd.delete(); exp_sd.delete();
    endtask

    // One byte slot: strobe for a cycle, then 3 idle cycles, then sample sdata
    task automatic send(input logic [7:0] b, input logic first);
        @(negedge clk);
        bus.mdata = b; bus.data_valid_read = 1'b1; bus.data_firstbyte = first;
        @(negedge clk);
        bus.data_valid_read = 1'b0; bus.data_firstbyte = 1'b0;
        repeat (3) @(negedge clk);
        act_sd.push_back(bus.sdata);
    endtask

    task automatic drive_txn(input logic [7:0] b[$]);
        foreach (b[i]) send(b[i], i == 0);
    endtask

    // Protocol model: bus cycles and master-visible bytes for one transaction
    task automatic model_txn(input logic [7:0] b[$]);
        logic rd, inc;
        logic [15:0] a;
        rd = b[0][7]; inc = b[0][6]; a = {b[1], b[2]};
        exp_sd.push_back(SYNC);
        exp_sd.push_back(SYNC);
        if (rd) begin
            exp_ev.push_back({1'b0, a, 8'h00});
            exp_sd.push_back(model_mem[a]);
        end else begin
            exp_sd.push_back(SYNC);
        end
        for (int i = 3; i < b.size(); i++) begin
            if (rd) begin
                if (inc) a = a + 16'd1;
                exp_ev.push_back({1'b0, a, 8'h00});
                exp_sd.push_back(model_mem[a]);
            end else begin
                exp_ev.push_back({1'b1, a, b[i]});
                model_mem[a] = b[i];
                if (inc) a = a + 16'd1;
                exp_sd.push_back(SYNC);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.sdata !== 8'h00)      begin n_fail++; $display("FAIL reset sdata: got %h want 00", bus.sdata); end
        n_checks++; if (bus.bus_addr !== 16'h0)   begin n_fail++; $display("FAIL reset bus_addr: got %h want 0000", bus.bus_addr); end
        n_checks++; if (bus.bus_wdata !== 8'h00)  begin n_fail++; $display("FAIL reset bus_wdata: got %h want 00", bus.bus_wdata); end
        n_checks++; if (bus.bus_we !== 1'b0)      begin n_fail++; $display("FAIL reset bus_we: got %b want 0", bus.bus_we); end
        n_checks++; if (bus.bus_re !== 1'b0)      begin n_fail++; $display("FAIL reset bus_re: got %b want 0", bus.bus_re); end
        n_checks++; if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        // a non-first strobe out of reset does nothing
        clr();
        send(8'h5C, 1'b0);
        n_checks++; if (act_ev.size() != 0) begin n_fail++; $display("FAIL reset idle_strobe: got %0d bus cycles want 0", act_ev.size()); end
        n_checks++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_write_ainc();
        clr();
        drive_txn('{8'h40, 8'h12, 8'h34, 8'hDE, 8'hAD});
        model_mem[16'h1234] = 8'hDE; model_mem[16'h1235] = 8'hAD;
        exp_ev = '{{1'b1, 16'h1234, 8'hDE}, {1'b1, 16'h1235, 8'hAD}};
        exp_sd = '{SYNC, SYNC, SYNC, SYNC, SYNC};
        n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL wr_ainc count: got %0d want %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) begin
            n_checks++;
            if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL wr_ainc ev%0d: got %h want %h", i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
        end
        foreach (exp_sd[i]) begin n_checks++; if (act_sd[i] !== exp_sd[i]) begin n_fail++; $display("FAIL wr_ainc sdata%0d: got %h want %h", i, act_sd[i], exp_sd[i]); end end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wr_ainc busy: got %b want 1", bus.busy); end
    endtask

    task automatic test_read_ainc();
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;
        model_mem[16'h0100] = 8'h11; model_mem[16'h0101] = 8'h22; model_mem[16'h0102] = 8'h33;
        clr();
        drive_txn('{8'hC0, 8'h01, 8'h00, 8'hE7, 8'h3B});
        exp_ev = '{{1'b0, 16'h0100, 8'h00}, {1'b0, 16'h0101, 8'h00}, {1'b0, 16'h0102, 8'h00}};
        exp_sd = '{SYNC, SYNC, 8'h11, 8'h22, 8'h33};
        n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL rd_ainc count: got %0d want %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) begin
            n_checks++;
            if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL rd_ainc ev%0d: got %h want %h", i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
        end
        foreach (exp_sd[i]) begin n_checks++; if (act_sd[i] !== exp_sd[i]) begin n_fail++; $display("FAIL rd_ainc sdata%0d: got %h want %h", i, act_sd[i], exp_sd[i]); end end
    endtask

    task automatic test_read_noinc();
        mem[16'h0200] = 8'h5A; model_mem[16'h0200] = 8'h5A;
        clr();
        drive_txn('{8'h80, 8'h02, 8'h00, 8'h00, 8'hFF});
        exp_ev = '{{1'b0, 16'h0200, 8'h00}, {1'b0, 16'h0200, 8'h00}, {1'b0, 16'h0200, 8'h00}};
        exp_sd = '{SYNC, SYNC, 8'h5A, 8'h5A, 8'h5A};
        n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL rd_noinc count: got %0d want %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) begin
            n_checks++;
            if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL rd_noinc ev%0d: got %h want %h", i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
        end
        foreach (exp_sd[i]) begin n_checks++; if (act_sd[i] !== exp_sd[i]) begin n_fail++; $display("FAIL rd_noinc sdata%0d: got %h want %h", i, act_sd[i], exp_sd[i]); end end
    endtask

    task automatic test_wrap();
        clr();
        drive_txn('{8'h40, 8'hFF, 8'hFF, 8'h01, 8'h02});
        model_mem[16'hFFFF] = 8'h01; model_mem[16'h0000] = 8'h02;
        exp_ev = '{{1'b1, 16'hFFFF, 8'h01}, {1'b1, 16'h0000, 8'h02}};
        n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL wrap count: got %0d want %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) begin
            n_checks++;
            if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL wrap ev%0d: got %h want %h", i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
        end
    endtask

    task automatic test_abort();
        clr();
        drive_txn('{8'h40, 8'h05, 8'h00, 8'h77});
        send(8'h00, 1'b1);                 // first-byte strobe while in DATA
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort busy: got %b want 1", bus.busy); end
        send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h55, 1'b0);
        model_mem[16'h0500] = 8'h77; model_mem[16'h0010] = 8'h55;
        exp_ev = '{{1'b1, 16'h0500, 8'h77}, {1'b1, 16'h0010, 8'h55}};
        n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL abort count: got %0d want %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) begin
            n_checks++;
            if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL abort ev%0d: got %h want %h", i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
        end
        n_checks++; if (act_sd[4] !== SYNC) begin n_fail++; $display("FAIL abort sdata: got %h want %h", act_sd[4], SYNC); end
    endtask

    task automatic test_random();
        logic [7:0]  b[$];
        logic [15:0] a;
        for (int t = 0; t < 25; t++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFD + 16'($urandom_range(0, 2));
            b.delete();
            b.push_back({1'($urandom), 1'($urandom), 6'($urandom)});
            b.push_back(a[15:8]);
            b.push_back(a[7:0]);
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) b.push_back(8'($urandom));
            clr();
            model_txn(b);
            drive_txn(b);
            n_checks++; if (act_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL rand%0d count: got %0d want %0d", t, act_ev.size(), exp_ev.size()); end
            foreach (exp_ev[i]) begin
                n_checks++;
                if (i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL rand%0d ev%0d: got %h want %h", t, i, (i < act_ev.size()) ? act_ev[i] : 25'h0, exp_ev[i]); end
            end
            foreach (exp_sd[i]) begin n_checks++; if (act_sd[i] !== exp_sd[i]) begin n_fail++; $display("FAIL rand%0d sdata%0d: got %h want %h", t, i, act_sd[i], exp_sd[i]); end end
        end
    endtask

    task automatic test_reset_midop();
        clr();
        drive_txn('{8'h00, 8'h30, 8'h00});
        // reset lands together with the DATA strobe, before its bus_we can register
        @(negedge clk);
        bus.mdata = 8'h99; bus.data_valid_read = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.data_valid_read = 1'b0;
        n_checks++; if (bus.bus_we !== 1'b0) begin n_fail++; $display("FAIL midrst we: got %b want 0", bus.bus_we); end
        n_checks++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.sdata !== 8'h00) begin n_fail++; $display("FAIL midrst sdata: got %h want 00", bus.sdata); end
        n_checks++; if (bus.bus_addr !== 16'h0) begin n_fail++; $display("FAIL midrst addr: got %h want 0000", bus.bus_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h42, 1'b0);
        n_checks++; if (act_ev.size() != 0) begin n_fail++; $display("FAIL midrst bus_cycles: got %0d want 0", act_ev.size()); end
        n_checks++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL midrst post_busy: got %b want 0", bus.busy); end
    endtask

    initial begin
        rst = 1'b1;
        bus.mdata = 8'h00; bus.data_valid_read = 1'b0; bus.data_firstbyte = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]       = 8'(i * 7 + 3);
            model_mem[i] = 8'(i * 7 + 3);
        end
        test_reset();
        test_write_ainc();
        test_read_ainc();
        test_read_noinc();
        test_wrap();
        test_abort();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
